// File: rtl/radix_seq_multiplier.sv
// rtl/radix_seq_multiplier.sv - shift-add sequential multiplier for MUL/MULH/MULHSU/MULHU
// Optional build macro SEQMUL_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are zero.
module radix_seq_multiplier #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [1:0]       mode_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] result_tag_o
);

  localparam int N     = WIDTH / RADIX_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int SH_W  = $clog2(2 * WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_rem_q, a_rem_d;
  logic [WIDTH-1:0]     b_mag_q, b_mag_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [1:0]           mode_q, mode_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [TAG_W-1:0]     result_tag_q, result_tag_d;
  logic                 result_valid_q, result_valid_d;

  logic                     a_neg, b_neg;
  logic [WIDTH-1:0]         a_mag, b_mag;
  logic [WIDTH-1:0]         a_rem_shift;
  logic [WIDTH+RADIX_BITS-1:0] pp;
  logic [2*WIDTH-1:0]       pp_ext;
  logic [SH_W-1:0]          shamt;
  logic [2*WIDTH-1:0]       prod;
  logic                     last_iter;

  // Operand signedness: a is signed for MULH/MULHSU, b only for MULH.
  assign a_neg = ((mode_i == 2'b01) || (mode_i == 2'b10)) && op_a_i[WIDTH-1];
  assign b_neg = (mode_i == 2'b01) && op_b_i[WIDTH-1];
  assign a_mag = a_neg ? (-op_a_i) : op_a_i;
  assign b_mag = b_neg ? (-op_b_i) : op_b_i;

  assign a_rem_shift = a_rem_q >> RADIX_BITS;
  assign pp     = {{RADIX_BITS{1'b0}}, b_mag_q} * {{WIDTH{1'b0}}, a_rem_q[RADIX_BITS-1:0]};
  assign pp_ext = {{(WIDTH-RADIX_BITS){1'b0}}, pp};
  assign shamt  = SH_W'(cnt_q) * SH_W'(RADIX_BITS);
  assign prod   = neg_q ? (-acc_q) : acc_q;

`ifdef SEQMUL_EARLY_OUT_EN
  assign last_iter = (cnt_q == CNT_W'(N - 1)) || (a_rem_shift == '0);
`else
  assign last_iter = (cnt_q == CNT_W'(N - 1));
`endif

  always_comb begin
    state_d        = state_q;
    a_rem_d        = a_rem_q;
    b_mag_d        = b_mag_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    neg_d          = neg_q;
    mode_d         = mode_q;
    tag_d          = tag_q;
    result_d       = result_q;
    result_tag_d   = result_tag_q;
    result_valid_d = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            a_rem_d = a_mag;
            b_mag_d = b_mag;
            neg_d   = a_neg ^ b_neg;
            mode_d  = mode_i;
            tag_d   = tag_i;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          acc_d   = acc_q + (pp_ext << shamt);
          a_rem_d = a_rem_shift;
          cnt_d   = cnt_q + 1'b1;
          if (last_iter) state_d = S_DONE;
        end
        S_DONE: begin
          result_valid_d = 1'b1;
          result_d       = (mode_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
          result_tag_d   = tag_q;
          state_d        = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      a_rem_q        <= '0;
      b_mag_q        <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      neg_q          <= 1'b0;
      mode_q         <= 2'b00;
      tag_q          <= '0;
      result_q       <= '0;
      result_tag_q   <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_rem_q        <= a_rem_d;
      b_mag_q        <= b_mag_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      neg_q          <= neg_d;
      mode_q         <= mode_d;
      tag_q          <= tag_d;
      result_q       <= result_d;
      result_tag_q   <= result_tag_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign ready_o        = (state_q == S_IDLE);
  assign busy_o         = ~ready_o;
  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;
  assign result_tag_o   = result_tag_q;

endmodule

// File: tb/tb_radix_seq_multiplier.sv
// tb/tb_radix_seq_multiplier.sv - scoreboard bench for radix_seq_multiplier
module tb_radix_seq_multiplier;

  localparam int W = 32;
  localparam int R = 2;
  localparam int T = 5;
  localparam int N = W / R;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] op_a_i = '0;
  logic [W-1:0] op_b_i = '0;
  logic [1:0]   mode_i = 2'b00;
  logic [T-1:0] tag_i = '0;
  logic         flush_i = 1'b0;
  logic         busy_o;
  logic         result_valid_o;
  logic [W-1:0] result_o;
  logic [T-1:0] result_tag_o;

  radix_seq_multiplier #(.WIDTH(W), .RADIX_BITS(R), .TAG_W(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .mode_i(mode_i), .tag_i(tag_i),
    .flush_i(flush_i), .busy_o(busy_o), .result_valid_o(result_valid_o),
    .result_o(result_o), .result_tag_o(result_tag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] res;
    logic [T-1:0] tag;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] m);
    logic [2*W-1:0] sa, sb_, p;
    sa = ((m == 2'b01) || (m == 2'b10)) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    sb_ = (m == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p = sa * sb_;
    return (m == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  function automatic int latency(input logic [W-1:0] a, input logic [1:0] m);
`ifdef SEQMUL_EARLY_OUT_EN
    logic [W-1:0] mag;
    int it;
    mag = (((m == 2'b01) || (m == 2'b10)) && a[W-1]) ? (-a) : a;
    it = 1;
    mag = mag >> R;
    while (mag != '0) begin
      it++;
      mag = mag >> R;
    end
    return it + 1;
`else
    if (m == 2'b11 && a == '1) return N + 1;
    return N + 1;
`endif
  endfunction

  // Result monitor: every strobe must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (result_valid_o) begin
        if (sb.size() == 0) begin
          check_eq("spurious_valid", 64'(result_valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("result", 64'(result_o), 64'(e.res));
          check_eq("tag", 64'(result_tag_o), 64'(e.tag));
          check_eq("latency_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!ready_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (!ready_o) check_eq("ready_timeout", 64'(ready_o), 64'd1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] m, input logic [T-1:0] t);
    exp_t e;
    @(negedge clk_i);
    wait_ready();
    op_a_i = a; op_b_i = b; mode_i = m; tag_i = t; valid_i = 1'b1;
    e.res = model(a, b, m);
    e.tag = t;
    e.cyc = cyc + 1 + latency(a, m);
    sb.push_back(e);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (sb.size() != 0) check_eq("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held_res;
    logic [T-1:0] held_tag;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_ready", 64'(ready_o), 64'd1);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_valid", 64'(result_valid_o), 64'd0);
    check_eq("rst_result", 64'(result_o), 64'd0);
    check_eq("rst_tag", 64'(result_tag_o), 64'd0);

    issue(32'd3, 32'd5, 2'b00, 5'd7);
    check_eq("busy_in_run", 64'(busy_o), 64'd1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 5'd1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 5'd2);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd3);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 5'd4);
    issue(32'h8000_0000, 32'h8000_0000, 2'b01, 5'd5);
    issue(32'h8000_0000, 32'h8000_0000, 2'b00, 5'd6);
    issue(32'd0, 32'h1234, 2'b00, 5'd8);
    issue(32'h100, 32'd3, 2'b00, 5'd9);
    for (int i = 0; i < 8; i++) begin
      issue($urandom, $urandom, 2'($urandom_range(0, 3)), 5'(i + 16));
    end
    drain();

    // Flush in the 5th RUN cycle with a competing request held alongside.
    held_res = result_o;
    held_tag = result_tag_o;
    op_a_i = 32'hFFFF_FFFF; op_b_i = 32'hFFFF_FFFF; mode_i = 2'b11; tag_i = 5'd30;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    op_a_i = 32'd9; op_b_i = 32'd9; mode_i = 2'b00; tag_i = 5'd31;
    valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    check_eq("flush_ready", 64'(ready_o), 64'd1);
    check_eq("flush_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    check_eq("flush_blocks_accept", 64'(ready_o), 64'd1);
    valid_i = 1'b0; flush_i = 1'b0;
    repeat (20) @(negedge clk_i);
    check_eq("flush_result_held", 64'(result_o), 64'(held_res));
    check_eq("flush_tag_held", 64'(result_tag_o), 64'(held_tag));
    issue(32'h0001_0000, 32'h0001_0000, 2'b11, 5'd10);
    drain();

    // Asynchronous reset in the middle of RUN.
    issue(32'hFFFF_FFFF, 32'h1234_5678, 2'b00, 5'd11);
    repeat (3) @(negedge clk_i);
    #1 rst_i = 1'b1;
    #2 rst_i = 1'b0;
    sb.delete();
    @(negedge clk_i);
    check_eq("midrst_ready", 64'(ready_o), 64'd1);
    check_eq("midrst_busy", 64'(busy_o), 64'd0);
    check_eq("midrst_result", 64'(result_o), 64'd0);
    check_eq("midrst_tag", 64'(result_tag_o), 64'd0);
    repeat (20) @(negedge clk_i);
    check_eq("midrst_no_result", 64'(result_o), 64'd0);
    issue(32'd7, 32'd6, 2'b00, 5'd12);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
